mixcol_seq: RTL

//   Sequencer that time-shares one combinational GF(2^8) multiplier (gal8_mul) to compute
//   AES MixColumns / InvMixColumns over a full 128-bit state, one product per cycle.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/gal8_mul.sv | 23 ++
 rtl/mixcol_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, MixColumns coefficients, FSM encoding and byte helper
package aes_pkg;

    localparam int         STATE_W  = 128;
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Index 0 is the coefficient applied to the byte on the diagonal of the matrix row.
    localparam logic [3:0][7:0] MIXCOL_FWD = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] MIXCOL_INV = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Byte 0 is the most significant byte of the state word.
    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s, input logic [3:0] k);
        get_byte = s[STATE_W-1 - 8*k -: 8];
    endfunction

endpackage

// File: rtl/gal8_mul.sv
// rtl/gal8_mul.sv - combinational GF(2^8) multiplier, reduction polynomial 0x11B
module gal8_mul
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] res
);

    logic [7:0] shifted;

    always_comb begin
        res     = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                res = res ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? AES_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/mixcol_seq.sv
// rtl/mixcol_seq.sv - MixColumns/InvMixColumns over a 128-bit state using one shared GF multiplier
module mixcol_seq
    import aes_pkg::*;
#(
    parameter logic INV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    mc_state_t          state;
    logic [5:0]         idx;
    logic [7:0]         acc;
    logic [STATE_W-1:0] s_cap;
    logic [STATE_W-1:0] res_buf;
    logic [STATE_W-1:0] res_next;
    logic [STATE_W-1:0] out_reg;
    logic               mode;

    logic [1:0] col;
    logic [1:0] row;
    logic [1:0] term;
    logic [1:0] cidx;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] prod;
    logic [7:0] res_byte;

    assign col  = idx[5:4];
    assign row  = idx[3:2];
    assign term = idx[1:0];
    // Two-bit subtraction wraps, giving the circulant matrix column offset.
    assign cidx = term - row;

    assign op_a     = get_byte(s_cap, {col, term});
    assign op_b     = mode ? MIXCOL_INV[cidx] : MIXCOL_FWD[cidx];
    assign res_byte = acc ^ prod;

    gal8_mul u_mul (
        .a   (op_a),
        .b   (op_b),
        .res (prod)
    );

    // Result byte 4*col+row is exactly idx[5:2].
    always_comb begin
        res_next = res_buf;
        res_next[STATE_W-1 - 8*idx[5:2] -: 8] = res_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 6'd0;
            acc     <= 8'h00;
            s_cap   <= '0;
            res_buf <= '0;
            out_reg <= '0;
            mode    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_cap <= in_state;
                        mode  <= in_inv & INV_EN;
                        idx   <= 6'd0;
                        acc   <= 8'h00;
                        state <= MUL;
                    end
                end
                MUL: begin
                    idx <= idx + 6'd1;
                    if (term == 2'd3) begin
                        acc     <= 8'h00;
                        res_buf <= res_next;
                    end else begin
                        acc <= res_byte;
                    end
                    if (idx == 6'd63) begin
                        out_reg <= res_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DONE);
    assign out_state = out_reg;

endmodule
